// File: rtl/assoc_directory.sv
// Set-associative coherence directory: per-set tag/state/presence/Tip storage with
// lookup, in-place update, lowest-free allocation and round-robin replacement.

module dir_tag_cmp #(
    parameter int TAG_W = 12
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] stored,
    input  logic [TAG_W-1:0] probe,
    output logic             match
);
    assign match = valid && (stored == probe);
endmodule

module assoc_directory #(
    parameter int ADDR_W     = 16,
    parameter int NUM_CACHES = 4,
    parameter int SETS       = 16,
    parameter int WAYS       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [2:0]              req_state,
    input  logic [NUM_CACHES-1:0]   req_presence,
    input  logic [NUM_CACHES-1:0]   req_tip,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [2:0]              resp_state,
    output logic [NUM_CACHES-1:0]   resp_presence,
    output logic [NUM_CACHES-1:0]   resp_tip,
    output logic [$clog2(WAYS)-1:0] resp_way,
    output logic                    evict_valid,
    output logic [ADDR_W-1:0]       evict_addr,
    output logic [NUM_CACHES-1:0]   evict_presence,
    output logic [NUM_CACHES-1:0]   evict_tip
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    localparam logic [2:0] DIR_STATE_INVALID = 3'd0;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W-1:0]     addr;
        logic [2:0]            state;
        logic [NUM_CACHES-1:0] presence;
        logic [NUM_CACHES-1:0] tip;
    } req_t;

    req_t             r_q;
    logic [1:0]       fsm_q;
    logic [IDX_W-1:0] init_idx_q;

    logic [SETS-1:0][WAYS-1:0]                 valid_q;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]      tag_q;
    logic [SETS-1:0][WAYS-1:0][2:0]            state_q;
    logic [SETS-1:0][WAYS-1:0][NUM_CACHES-1:0] pres_q;
    logic [SETS-1:0][WAYS-1:0][NUM_CACHES-1:0] tip_q;
    logic [SETS-1:0][WAY_W-1:0]                rr_q;

    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic [WAYS-1:0]  match;
    logic             hit, any_free, upd_live;
    logic [WAY_W-1:0] hit_way, free_way, alloc_way;

    assign r_idx     = r_q.addr[IDX_W-1:0];
    assign r_tag     = r_q.addr[ADDR_W-1:IDX_W];
    assign req_ready = (fsm_q == ST_IDLE);
    assign upd_live  = (r_q.state != DIR_STATE_INVALID);
    assign alloc_way = any_free ? free_way : rr_q[r_idx];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dir_tag_cmp #(.TAG_W(TAG_W)) u_cmp (
            .valid  (valid_q[r_idx][w]),
            .stored (tag_q[r_idx][w]),
            .probe  (r_tag),
            .match  (match[w])
        );
    end

    // Descending scan so the lowest matching / lowest free way wins.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        any_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[r_idx][w]) begin
                any_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    logic                  wr_en, wr_vld, evict_now;
    logic [WAY_W-1:0]      wr_way, n_way;
    logic [2:0]            n_state;
    logic [NUM_CACHES-1:0] n_pres, n_tip;

    always_comb begin
        wr_en     = 1'b0;
        wr_vld    = 1'b0;
        evict_now = 1'b0;
        wr_way    = '0;
        n_way     = '0;
        n_state   = DIR_STATE_INVALID;
        n_pres    = '0;
        n_tip     = '0;
        if (!r_q.write) begin
            if (hit) begin
                n_way   = hit_way;
                n_state = state_q[r_idx][hit_way];
                n_pres  = pres_q[r_idx][hit_way];
                n_tip   = tip_q[r_idx][hit_way];
            end
        end else if (hit) begin
            // Writing INVALID over a hit is a deallocation: only the valid bit drops.
            wr_en  = 1'b1;
            wr_way = hit_way;
            wr_vld = upd_live;
            n_way  = hit_way;
            if (upd_live) begin
                n_state = r_q.state;
                n_pres  = r_q.presence;
                n_tip   = r_q.tip;
            end
        end else if (upd_live) begin
            wr_en     = 1'b1;
            wr_way    = alloc_way;
            wr_vld    = 1'b1;
            n_way     = alloc_way;
            n_state   = r_q.state;
            n_pres    = r_q.presence;
            n_tip     = r_q.tip;
            evict_now = !any_free;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q          <= ST_INIT;
            init_idx_q     <= '0;
            r_q            <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_state     <= '0;
            resp_presence  <= '0;
            resp_tip       <= '0;
            resp_way       <= '0;
            evict_valid    <= 1'b0;
            evict_addr     <= '0;
            evict_presence <= '0;
            evict_tip      <= '0;
        end else begin
            resp_valid  <= 1'b0;
            evict_valid <= 1'b0;
            case (fsm_q)
                ST_INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == IDX_W'(SETS - 1)) fsm_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_q   <= '{req_write, req_addr, req_state, req_presence, req_tip};
                        fsm_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    fsm_q         <= ST_IDLE;
                    resp_valid    <= 1'b1;
                    resp_hit      <= hit;
                    resp_state    <= n_state;
                    resp_presence <= n_pres;
                    resp_tip      <= n_tip;
                    resp_way      <= n_way;
                    if (evict_now) begin
                        evict_valid    <= 1'b1;
                        evict_addr     <= {tag_q[r_idx][alloc_way], r_idx};
                        evict_presence <= pres_q[r_idx][alloc_way];
                        evict_tip      <= tip_q[r_idx][alloc_way];
                    end
                end
                default: fsm_q <= ST_INIT;
            endcase
        end
    end

    // Array storage needs no reset: the INIT sweep clears valid bits and pointers.
    always_ff @(posedge clk) begin
        if (fsm_q == ST_INIT) begin
            valid_q[init_idx_q] <= '0;
            rr_q[init_idx_q]    <= '0;
        end else if (fsm_q == ST_ACCESS && wr_en) begin
            valid_q[r_idx][wr_way] <= wr_vld;
            if (wr_vld) begin
                tag_q[r_idx][wr_way]   <= r_tag;
                state_q[r_idx][wr_way] <= r_q.state;
                pres_q[r_idx][wr_way]  <= r_q.presence;
                tip_q[r_idx][wr_way]   <= r_q.tip;
            end
            if (evict_now) rr_q[r_idx] <= rr_q[r_idx] + 1'b1;
        end
    end
endmodule

// File: doc/assoc_directory.md
ASSOC_DIRECTORY -- requirements
Module: assoc_directory

Interface
REQ-001 The block SHALL expose these parameters: ADDR_W, default 16, line-address width; NUM_CACHES, default 4, number of L1 caches; SETS, default 16, directory sets (power of two, >=2); WAYS, default 4, ways per set (power of two, >=2).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named as in the codebase:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
REQ-003 Request ports SHALL be:
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  0 lookup, 1 update
- req_addr  in  ADDR_W  line address; index = low clog2(SETS) bits, tag = remainder
- req_state  in  3  new DIR_STATE_* for an update
- req_presence  in  NUM_CACHES  new presence vector
- req_tip  in  NUM_CACHES  new Tip vector
REQ-004 Response ports SHALL be:
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  tag matched a valid way
- resp_state  out  3  entry state
- resp_presence  out  NUM_CACHES  entry presence vector
- resp_tip  out  NUM_CACHES  entry Tip vector
- resp_way  out  clog2(WAYS)  matched or allocated way
REQ-005 Eviction ports SHALL be:
- evict_valid  out  1  valid entry displaced
- evict_addr  out  ADDR_W  victim address, rebuilt from tag and index
- evict_presence  out  NUM_CACHES  victim presence vector
- evict_tip  out  NUM_CACHES  victim Tip vector

Function
REQ-006 FSM states SHALL be INIT, IDLE and ACCESS; req_ready SHALL be high only in IDLE.
REQ-007 INIT SHALL clear every way's valid bit and the round-robin pointer of set k in its k-th cycle, then go to IDLE after exactly SETS cycles.
REQ-008 Acceptance at clock edge E SHALL register the request and enter ACCESS.
REQ-009 At edge E+1 the block SHALL do the tag compare and any array write, register all response outputs, pulse resp_valid for one cycle, and return to IDLE, giving a sustained rate of one request per two cycles.
REQ-010 req_* inputs SHALL be ignored outside an accepting cycle.
REQ-011 Lookup hit SHALL return the stored state, presence, Tip and way, with resp_hit=1.
REQ-012 Lookup miss SHALL return resp_hit=0, state DIR_STATE_INVALID, zero vectors and resp_way=0.
REQ-013 A lookup SHALL modify no state.
REQ-014 An update that hits with req_state != DIR_STATE_INVALID SHALL overwrite that way in place.
REQ-015 An update that hits with req_state == DIR_STATE_INVALID SHALL clear that way's valid bit.
REQ-016 An update that misses with DIR_STATE_INVALID SHALL change nothing.
REQ-017 An update that misses with any other state SHALL allocate the lowest-index invalid way; if all ways are valid it SHALL use way rr_ptr[set], then increment rr_ptr mod WAYS.
REQ-018 When a valid entry is displaced, evict_valid SHALL pulse in the same cycle as resp_valid, with the victim's address and vectors.
REQ-019 Update responses SHALL report resp_hit as the pre-write match result, and the written values (all zero for a deallocation) plus the way used.
REQ-020 A request following an update SHALL observe the updated contents, with no bypass hazard.
REQ-021 evict_* data and resp_* data SHALL hold their last values when their pulses are low.

Reset
REQ-022 Asserting rst_n at any time SHALL immediately set req_ready, resp_valid, evict_valid and all data outputs to 0, discard any pending request, and force INIT.
REQ-023 Deasserting rst_n SHALL start the INIT sweep from set 0.

Verification
REQ-024 Release reset (defaults): req_ready stays 0 for exactly 16 cycles, then goes 1; lookup 0x0005 then returns resp_hit=0, state DIR_STATE_INVALID, presence 4'b0000.
REQ-025 Update 0x0123 with presence 4'b0011 and Tip 4'b0001, then look up 0x0123: resp_valid pulses one cycle after each ACCESS edge; hit=1, presence 4'b0011, Tip 4'b0001.
REQ-026 Update 0x0013, 0x0023, 0x0033, 0x0043: these fill ways 0-3 with no evict_valid. Updating 0x0053 then gives evict_valid=1, evict_addr=0x0013, resp_way=0; updating 0x0063 evicts 0x0023 from way 1.
REQ-027 Update 0x0033 with DIR_STATE_INVALID, then update 0x0073: the second update allocates way 2 with no eviction, and a lookup of 0x0033 misses.
REQ-028 Assert rst_n during ACCESS of an update: no resp_valid appears, INIT reruns, and a lookup of that address then misses.
REQ-029 Hold req_valid high continuously: acceptances occur every second cycle, exactly one resp_valid per accepted request, none while req_ready=0.
